sdrc_port_arbiter: RTL and testbench

//  Round-robin arbiter sharing the SDRAM request path among NPORTS application ports.

---
 rtl/sdrc_arb_pkg.sv | 32 +++
 rtl/sdrc_port_arbiter_if.sv | 39 +++
 rtl/sdrc_addr_map.sv | 31 +++
 rtl/sdrc_port_arbiter.sv | 163 ++++++++++++++++
 tb/tb_sdrc_port_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sdrc_arb_pkg.sv
// sdrc_arb_pkg: shared types, field widths and round-robin pick helper
// for the SDRAM port arbiter.
package sdrc_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        SPLIT = 2'd2,
        ACK   = 2'd3
    } arb_state_e;

    localparam int COLBITS_BASE = 8;
    localparam int ROW_W        = 13;
    localparam int BA_W         = 2;

    // Unused upper request bits must be zero; wrapping over 8 then skips them.
    function automatic logic [2:0] rr_pick(input logic [7:0] req,
                                           input logic [2:0] ptr);
        logic [2:0] idx;
        logic       found;
        rr_pick = ptr;
        found   = 1'b0;
        for (int i = 0; i < 8; i++) begin
            idx = ptr + 3'(i);
            if (!found && req[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/sdrc_port_arbiter_if.sv
// sdrc_port_arbiter_if: application-port and bank-controller request
// signals; master = arbiter side, slave = environment side.
interface sdrc_port_arbiter_if
    import sdrc_arb_pkg::*;
#(
    parameter int NPORTS = 4,
    parameter int APP_AW = 26,
    parameter int LEN_W  = 7
);
    localparam int PW = $clog2(NPORTS);

    logic [NPORTS-1:0]        app_req;
    logic [NPORTS*APP_AW-1:0] app_addr;
    logic [NPORTS*LEN_W-1:0]  app_len;
    logic [NPORTS-1:0]        app_wr;
    logic [NPORTS-1:0]        app_ack;

    logic                     r2b_req;
    logic [BA_W-1:0]          r2b_ba;
    logic [ROW_W-1:0]         r2b_raddr;
    logic [ROW_W-1:0]         r2b_caddr;
    logic [LEN_W-1:0]         r2b_len;
    logic                     r2b_write;
    logic [PW-1:0]            r2b_port;
    logic                     b2r_arb_ok;

    modport master (
        input  app_req, app_addr, app_len, app_wr, b2r_arb_ok,
        output app_ack, r2b_req, r2b_ba, r2b_raddr, r2b_caddr,
        output r2b_len, r2b_write, r2b_port
    );

    modport slave (
        output app_req, app_addr, app_len, app_wr, b2r_arb_ok,
        input  app_ack, r2b_req, r2b_ba, r2b_raddr, r2b_caddr,
        input  r2b_len, r2b_write, r2b_port
    );

endinterface

// File: rtl/sdrc_addr_map.sv
// sdrc_addr_map: linear word address -> bank/row/column for a
// column width of 8+colbits; also reports the page size in words.
module sdrc_addr_map
    import sdrc_arb_pkg::*;
#(
    parameter int APP_AW = 26
) (
    input  logic [APP_AW-1:0] addr_i,
    input  logic [1:0]        colbits_i,
    output logic [BA_W-1:0]   ba_o,
    output logic [ROW_W-1:0]  raddr_o,
    output logic [ROW_W-1:0]  caddr_o,
    output logic [ROW_W-1:0]  page_o
);
    logic [4:0]              c;
    logic [31:0]             a32;
    logic [31:0]             mask;
    logic [BA_W+ROW_W-1:0]   hi;

    always_comb begin
        c       = 5'(COLBITS_BASE) + {3'b000, colbits_i};
        a32     = 32'(addr_i);
        mask    = (32'd1 << c) - 32'd1;
        hi      = (BA_W+ROW_W)'(a32 >> c);
        caddr_o = ROW_W'(a32 & mask);
        ba_o    = hi[BA_W-1:0];
        raddr_o = hi[BA_W +: ROW_W];
        page_o  = ROW_W'(32'd1 << c);
    end

endmodule

// File: rtl/sdrc_port_arbiter.sv
// sdrc_port_arbiter: round-robin grant of application ports onto the bank
// request path. Define SDRC_ARB_PAGE_SPLIT_EN to split page-crossing bursts.
module sdrc_port_arbiter
    import sdrc_arb_pkg::*;
#(
    parameter int NPORTS = 4,
    parameter int APP_AW = 26,
    parameter int LEN_W  = 7
) (
    input  logic                sdram_clk,
    input  logic                sdram_reset,
    input  logic [1:0]          cfg_colbits,
    sdrc_port_arbiter_if.master bus
);
    localparam int PW = $clog2(NPORTS);

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_ISSUE = ISSUE;
    localparam logic [1:0] ST_ACK   = ACK;
`ifdef SDRC_ARB_PAGE_SPLIT_EN
    localparam logic [1:0] ST_SPLIT = SPLIT;
`endif

    logic [1:0]        state_q, state_d;
    logic [PW-1:0]     rr_q, rr_d;
    logic [PW-1:0]     port_q, port_d;
    logic [BA_W-1:0]   ba_q, ba_d;
    logic [ROW_W-1:0]  raddr_q, raddr_d;
    logic [ROW_W-1:0]  caddr_q, caddr_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic              wr_q, wr_d;

    logic [PW-1:0]     gport;
    logic [APP_AW-1:0] gaddr;
    logic [LEN_W-1:0]  glen, len_e;
    logic [BA_W-1:0]   map_ba;
    logic [ROW_W-1:0]  map_raddr, map_caddr;

`ifdef SDRC_ARB_PAGE_SPLIT_EN
    logic [LEN_W-1:0]  rem_q, rem_d, len1;
    logic [ROW_W-1:0]  map_page;
    logic [ROW_W:0]    end_col;
`endif

    assign gport = PW'(rr_pick(8'(bus.app_req), 3'(rr_q)));
    assign gaddr = bus.app_addr[int'(gport)*APP_AW +: APP_AW];
    assign glen  = bus.app_len[int'(gport)*LEN_W +: LEN_W];
    assign len_e = (glen == '0) ? LEN_W'(1) : glen;

    sdrc_addr_map #(.APP_AW(APP_AW)) u_map (
        .addr_i    (gaddr),
        .colbits_i (cfg_colbits),
        .ba_o      (map_ba),
        .raddr_o   (map_raddr),
        .caddr_o   (map_caddr),
`ifdef SDRC_ARB_PAGE_SPLIT_EN
        .page_o    (map_page)
`else
        .page_o    ()
`endif
    );

`ifdef SDRC_ARB_PAGE_SPLIT_EN
    assign end_col = {1'b0, map_caddr} + (ROW_W+1)'(len_e);
    assign len1    = LEN_W'(map_page - map_caddr);
`endif

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        port_d  = port_q;
        ba_d    = ba_q;
        raddr_d = raddr_q;
        caddr_d = caddr_q;
        len_d   = len_q;
        wr_d    = wr_q;
`ifdef SDRC_ARB_PAGE_SPLIT_EN
        rem_d   = rem_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (|bus.app_req) begin
                    port_d  = gport;
                    ba_d    = map_ba;
                    raddr_d = map_raddr;
                    caddr_d = map_caddr;
                    len_d   = len_e;
                    wr_d    = bus.app_wr[gport];
`ifdef SDRC_ARB_PAGE_SPLIT_EN
                    rem_d   = '0;
                    if (end_col > {1'b0, map_page}) begin
                        len_d = len1;
                        rem_d = len_e - len1;
                    end
`endif
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (bus.b2r_arb_ok) begin
`ifdef SDRC_ARB_PAGE_SPLIT_EN
                    state_d = (rem_q != '0) ? ST_SPLIT : ST_ACK;
`else
                    state_d = ST_ACK;
`endif
                end
            end
`ifdef SDRC_ARB_PAGE_SPLIT_EN
            ST_SPLIT: begin
                // Next row of the same bank; row counter wraps naturally
                caddr_d = '0;
                raddr_d = raddr_q + ROW_W'(1);
                len_d   = rem_q;
                rem_d   = '0;
                state_d = ST_ISSUE;
            end
`endif
            ST_ACK: begin
                rr_d    = (port_q == PW'(NPORTS-1)) ? '0 : port_q + PW'(1);
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sdram_clk) begin
        if (sdram_reset) begin
            state_q <= ST_IDLE;
            rr_q    <= '0;
            port_q  <= '0;
            ba_q    <= '0;
            raddr_q <= '0;
            caddr_q <= '0;
            len_q   <= '0;
            wr_q    <= 1'b0;
`ifdef SDRC_ARB_PAGE_SPLIT_EN
            rem_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            port_q  <= port_d;
            ba_q    <= ba_d;
            raddr_q <= raddr_d;
            caddr_q <= caddr_d;
            len_q   <= len_d;
            wr_q    <= wr_d;
`ifdef SDRC_ARB_PAGE_SPLIT_EN
            rem_q   <= rem_d;
`endif
        end
    end

    assign bus.r2b_req   = (state_q == ST_ISSUE);
    assign bus.r2b_ba    = ba_q;
    assign bus.r2b_raddr = raddr_q;
    assign bus.r2b_caddr = caddr_q;
    assign bus.r2b_len   = len_q;
    assign bus.r2b_write = wr_q;
    assign bus.r2b_port  = port_q;
    assign bus.app_ack   = (state_q == ST_ACK) ? (NPORTS'(1) << port_q) : '0;

endmodule

// File: tb/tb_sdrc_port_arbiter.sv
// tb_sdrc_port_arbiter: directed scenarios plus random traffic checked
// against a transaction-queue reference model of the arbiter.
module tb_sdrc_port_arbiter;
    import sdrc_arb_pkg::*;

    localparam int NP = 4;
    localparam int AW = 26;
    localparam int LW = 7;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] colbits;
    logic       ok;

    always #5 clk = ~clk;

    sdrc_port_arbiter_if #(.NPORTS(NP), .APP_AW(AW), .LEN_W(LW)) bus ();

    sdrc_port_arbiter #(.NPORTS(NP), .APP_AW(AW), .LEN_W(LW)) dut (
        .sdram_clk   (clk),
        .sdram_reset (rst),
        .cfg_colbits (colbits),
        .bus         (bus)
    );

    int errors = 0;
    int checks = 0;

    logic          tb_req [NP];
    logic [AW-1:0] tb_addr[NP];
    logic [LW-1:0] tb_len [NP];
    logic          tb_wr  [NP];

    typedef struct {
        bit gap;
        int ba;
        int raddr;
        int caddr;
        int len;
        int wr;
        int port;
    } iss_t;

    iss_t q[$];
    int   m_ack = -1;
    int   m_rr  = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic iss_t mk(bit gap, int ba, int ra, int ca, int len,
                                int wr, int port);
        iss_t e;
        e.gap = gap; e.ba = ba; e.raddr = ra; e.caddr = ca;
        e.len = len; e.wr = wr; e.port = port;
        return e;
    endfunction

    task automatic model_grant();
        int w, page, a, ca, ba, ra, len, l1;
        bit split;
        w = -1;
        for (int i = 0; i < NP; i++) begin
            int p;
            p = (m_rr + i) % NP;
            if (w < 0 && tb_req[p]) w = p;
        end
        if (w < 0) return;
        page = 1 << (8 + int'(colbits));
        a    = int'(tb_addr[w]);
        ca   = a % page;
        ba   = (a / page) % 4;
        ra   = (a / (page * 4)) % 8192;
        len  = (tb_len[w] == 0) ? 1 : int'(tb_len[w]);
        split = 1'b0;
`ifdef SDRC_ARB_PAGE_SPLIT_EN
        split = (ca + len > page);
`endif
        if (split) begin
            l1 = page - ca;
            q.push_back(mk(0, ba, ra, ca, l1, int'(tb_wr[w]), w));
            q.push_back(mk(1, 0, 0, 0, 0, 0, w));
            q.push_back(mk(0, ba, (ra + 1) % 8192, 0, len - l1, int'(tb_wr[w]), w));
        end else begin
            q.push_back(mk(0, ba, ra, ca, len, int'(tb_wr[w]), w));
        end
    endtask

    task automatic model_advance();
        int cur;
        if (rst) begin
            q.delete();
            m_ack = -1;
            m_rr  = 0;
        end else if (q.size() > 0) begin
            if (q[0].gap) begin
                void'(q.pop_front());
            end else if (ok) begin
                cur = q[0].port;
                void'(q.pop_front());
                if (q.size() == 0) m_ack = cur;
            end
        end else if (m_ack >= 0) begin
            m_rr  = (m_ack + 1) % NP;
            m_ack = -1;
        end else begin
            model_grant();
        end
    endtask

    task automatic check_outputs();
        bit exp_req;
        exp_req = (q.size() > 0) && !q[0].gap;
        check("r2b_req", longint'(bus.r2b_req), longint'(exp_req));
        if (exp_req) begin
            check("r2b_ba",    longint'(bus.r2b_ba),    longint'(q[0].ba));
            check("r2b_raddr", longint'(bus.r2b_raddr), longint'(q[0].raddr));
            check("r2b_caddr", longint'(bus.r2b_caddr), longint'(q[0].caddr));
            check("r2b_len",   longint'(bus.r2b_len),   longint'(q[0].len));
            check("r2b_write", longint'(bus.r2b_write), longint'(q[0].wr));
            check("r2b_port",  longint'(bus.r2b_port),  longint'(q[0].port));
        end
        check("app_ack", longint'(bus.app_ack),
              (m_ack >= 0) ? (longint'(1) << m_ack) : 0);
    endtask

    task automatic drive();
        for (int p = 0; p < NP; p++) begin
            bus.app_req[p]             = tb_req[p];
            bus.app_addr[p*AW +: AW]   = tb_addr[p];
            bus.app_len[p*LW +: LW]    = tb_len[p];
            bus.app_wr[p]              = tb_wr[p];
        end
        bus.b2r_arb_ok = ok;
    endtask

    task automatic tick();
        drive();
        check_outputs();
        model_advance();
        @(negedge clk);
    endtask

    task automatic set_port(int p, logic [AW-1:0] a, logic [LW-1:0] l, logic w);
        tb_req[p]  = 1'b1;
        tb_addr[p] = a;
        tb_len[p]  = l;
        tb_wr[p]   = w;
    endtask

    task automatic new_req(int p);
        logic [AW-1:0] a;
        a = AW'($urandom);
        if ($urandom_range(0, 3) == 0) a[7:4] = 4'hF;
        set_port(p, a, LW'($urandom_range(0, 127)), 1'($urandom));
    endtask

    task automatic settle();
        for (int i = 0; i < 30; i++) begin
            int busy_p;
            busy_p = (q.size() > 0) ? q[0].port : -1;
            for (int p = 0; p < NP; p++)
                if (p != busy_p) tb_req[p] = 1'b0;
            ok = 1'b1;
            tick();
            if (q.size() == 0 && m_ack < 0) break;
        end
        check("settle_idle", longint'(q.size() + (m_ack >= 0 ? 1 : 0)), 0);
    endtask

    initial begin
        int order[$];
        int exp_order[5];
        int ntx, nack, l_first, c_second, r_first, r_second, l_second;

        exp_order = '{0, 1, 2, 3, 0};
        for (int p = 0; p < NP; p++) begin
            tb_req[p] = 1'b0; tb_addr[p] = '0; tb_len[p] = '0; tb_wr[p] = 1'b0;
        end
        rst = 1'b1; ok = 1'b0; colbits = 2'd0;
        drive();
        @(negedge clk);

        // reset held 3 cycles, then idle with no requests
        for (int i = 0; i < 3; i++) tick();
        rst = 1'b0;
        check("rst_req",   longint'(bus.r2b_req),   0);
        check("rst_ba",    longint'(bus.r2b_ba),    0);
        check("rst_raddr", longint'(bus.r2b_raddr), 0);
        check("rst_caddr", longint'(bus.r2b_caddr), 0);
        check("rst_len",   longint'(bus.r2b_len),   0);
        check("rst_port",  longint'(bus.r2b_port),  0);
        check("rst_ack",   longint'(bus.app_ack),   0);
        for (int i = 0; i < 3; i++) tick();

        // single port-2 request with known address split
        ok = 1'b1;
        set_port(2, 26'h0012345, 7'd4, 1'b1);
        tick();
        check("t2_req",   longint'(bus.r2b_req),   1);
        check("t2_ba",    longint'(bus.r2b_ba),    3);
        check("t2_raddr", longint'(bus.r2b_raddr), 'h48);
        check("t2_caddr", longint'(bus.r2b_caddr), 'h45);
        check("t2_len",   longint'(bus.r2b_len),   4);
        check("t2_port",  longint'(bus.r2b_port),  2);
        tick();
        check("t2_ack", longint'(bus.app_ack), 'b0100);
        tb_req[2] = 1'b0;
        settle();

        // all ports continuously requesting after reset
        rst = 1'b1; tick(); rst = 1'b0;
        for (int p = 0; p < NP; p++) set_port(p, AW'(p << 12), 7'd2, 1'(p));
        ok = 1'b1;
        for (int i = 0; i < 40 && order.size() < 5; i++) begin
            for (int p = 0; p < NP; p++)
                if (bus.app_ack[p]) order.push_back(p);
            tick();
        end
        for (int k = 0; k < 5; k++)
            check($sformatf("rr_order%0d", k),
                  longint'((order.size() > k) ? order[k] : -1),
                  longint'(exp_order[k]));
        settle();

        // stall with b2r_arb_ok low for 5 cycles
        set_port(1, 26'h0345678, 7'd16, 1'b0);
        ok = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        ok = 1'b1;
        tick();
        tick();
        tb_req[1] = 1'b0;
        settle();

        // page-crossing request near end of an 8-bit column page
        colbits = 2'd0;
        set_port(0, 26'h00123FC, 7'd8, 1'b1);
        ok = 1'b1;
        ntx = 0; nack = 0; l_first = -1; l_second = -1;
        c_second = -1; r_first = -1; r_second = -1;
        for (int i = 0; i < 10; i++) begin
            if (bus.r2b_req && ok) begin
                ntx++;
                if (ntx == 1) begin
                    l_first = int'(bus.r2b_len); r_first = int'(bus.r2b_raddr);
                end
                if (ntx == 2) begin
                    l_second = int'(bus.r2b_len); c_second = int'(bus.r2b_caddr);
                    r_second = int'(bus.r2b_raddr);
                end
            end
            if (bus.app_ack != '0) nack++;
            if (m_ack == 0) tb_req[0] = 1'b0;
            tick();
        end
        check("pg_acks",   longint'(nack),    1);
        check("pg_raddr1", longint'(r_first), 'h48);
`ifdef SDRC_ARB_PAGE_SPLIT_EN
        check("pg_ntx",    longint'(ntx),      2);
        check("pg_len1",   longint'(l_first),  4);
        check("pg_len2",   longint'(l_second), 4);
        check("pg_caddr2", longint'(c_second), 0);
        check("pg_raddr2", longint'(r_second), 'h49);
`else
        check("pg_ntx",    longint'(ntx),     1);
        check("pg_len1",   longint'(l_first), 8);
`endif
        settle();

        // reset during ISSUE: request dropped, pointer back to 0
        set_port(3, 26'h0000100, 7'd3, 1'b0);
        ok = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mr_req", longint'(bus.r2b_req), 0);
        check("mr_ack", longint'(bus.app_ack), 0);
        for (int p = 0; p < NP; p++) set_port(p, AW'(p << 10), 7'd1, 1'b0);
        ok = 1'b1;
        tick();
        check("mr_req2",  longint'(bus.r2b_req),  1);
        check("mr_port0", longint'(bus.r2b_port), 0);
        settle();

        // random traffic
        for (int i = 0; i < 2000; i++) begin
            for (int p = 0; p < NP; p++) begin
                if (m_ack == p) begin
                    if ($urandom_range(0, 1) == 1) new_req(p);
                    else tb_req[p] = 1'b0;
                end else if (!tb_req[p] && $urandom_range(0, 3) == 0) begin
                    new_req(p);
                end
            end
            ok = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 9) == 0) colbits = 2'($urandom);
            rst = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 1'b0;
        settle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
